// File: rtl/bsk_mgr_cut_scheduler.sv
// bsk_mgr_cut_scheduler: round-robin, credit-gated BSK fetch request issue over a runtime-selected number of cuts.
// Optional perf counters are enabled by defining BSK_MGR_CUT_SCHED_PERF_EN.
module bsk_mgr_cut_scheduler #(
    parameter int BSK_CUT_NB = 4,
    parameter int SLOT_NB    = 2,
    parameter int BR_LOOP_W  = 10,
    localparam int CNB_W = $clog2(BSK_CUT_NB + 1),
    localparam int CID_W = (BSK_CUT_NB > 1) ? $clog2(BSK_CUT_NB) : 1
) (
    input  logic                    clk,
    input  logic                    s_rst,
    input  logic                    cmd_vld,
    output logic                    cmd_rdy,
    input  logic [BR_LOOP_W-1:0]    cmd_br_loop,
    input  logic [CNB_W-1:0]        cmd_cut_nb,
    output logic                    req_vld,
    input  logic                    req_rdy,
    output logic [CID_W-1:0]        req_cut_id,
    output logic [BR_LOOP_W-1:0]    req_br_loop,
    output logic                    req_last,
    input  logic [BSK_CUT_NB-1:0]   slot_release,
    output logic [BSK_CUT_NB*4-1:0] credit,
    output logic                    busy
`ifdef BSK_MGR_CUT_SCHED_PERF_EN
    ,
    output logic [31:0]             perf_stall_cnt,
    output logic [31:0]             perf_cmd_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
    state_e                state_q, state_d;
    logic [BR_LOOP_W-1:0]  br_loop_q, br_loop_d;
    logic [CNB_W-1:0]      cut_nb_q, cut_nb_d;
    logic [BSK_CUT_NB-1:0] issued_q, issued_d;
    logic [CID_W-1:0]      ptr_q, ptr_d;
    logic [3:0]            credit_q [BSK_CUT_NB];
    logic [3:0]            credit_d [BSK_CUT_NB];
    logic                  req_vld_q, req_vld_d;
    logic                  req_last_q, req_last_d;
    logic [CID_W-1:0]      req_cut_id_q, req_cut_id_d;
    logic [BR_LOOP_W-1:0]  req_br_loop_q, req_br_loop_d;
    logic [BSK_CUT_NB-1:0] active, cand, acc, mask_after;
    logic                  found;
    logic [CID_W-1:0]      pick;
    logic [CNB_W-1:0]      nxt_id;
    int                    idx;

    always_comb begin
        for (int i = 0; i < BSK_CUT_NB; i++) begin
            active[i] = i < int'(cut_nb_q);
            cand[i]   = active[i] && !issued_q[i] && credit_q[i] != 4'd0;
            acc[i]    = state_q == WAIT && req_rdy && int'(req_cut_id_q) == i;
        end
    end

    // Scan downward so the candidate closest at/after the pointer is the last one written.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = BSK_CUT_NB - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= BSK_CUT_NB) idx = idx - BSK_CUT_NB;
            if (cand[idx]) begin
                found = 1'b1;
                pick  = CID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        br_loop_d     = br_loop_q;
        cut_nb_d      = cut_nb_q;
        issued_d      = issued_q;
        ptr_d         = ptr_q;
        req_vld_d     = req_vld_q;
        req_last_d    = req_last_q;
        req_cut_id_d  = req_cut_id_q;
        req_br_loop_d = req_br_loop_q;
        cmd_rdy       = 1'b0;
        busy          = state_q != IDLE;
        mask_after    = issued_q | (BSK_CUT_NB'(1) << pick);
        nxt_id        = CNB_W'(req_cut_id_q) + CNB_W'(1);
        case (state_q)
            IDLE: begin
                cmd_rdy = !s_rst;
                if (cmd_vld && !s_rst) begin
                    br_loop_d = cmd_br_loop;
                    cut_nb_d  = (cmd_cut_nb == '0 || int'(cmd_cut_nb) > BSK_CUT_NB) ? CNB_W'(BSK_CUT_NB) : cmd_cut_nb;
                    issued_d  = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (found) begin
                    req_vld_d     = 1'b1;
                    req_cut_id_d  = pick;
                    req_br_loop_d = br_loop_q;
                    req_last_d    = (mask_after & active) == active;
                    state_d       = WAIT;
                end
            end
            WAIT: begin
                if (req_rdy) begin
                    req_vld_d  = 1'b0;
                    req_last_d = 1'b0;
                    issued_d   = issued_q | (BSK_CUT_NB'(1) << req_cut_id_q);
                    ptr_d      = (nxt_id >= cut_nb_q) ? '0 : CID_W'(nxt_id);
                    state_d    = req_last_q ? IDLE : ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A release at full credit only counts when it coincides with an accept on that cut.
    always_comb begin
        for (int i = 0; i < BSK_CUT_NB; i++)
            credit_d[i] = credit_q[i]
                        + 4'(slot_release[i] && (credit_q[i] != 4'(SLOT_NB) || acc[i]))
                        - 4'(acc[i]);
    end

    always_ff @(posedge clk) begin
        if (s_rst) begin
            state_q       <= IDLE;
            br_loop_q     <= '0;
            cut_nb_q      <= '0;
            issued_q      <= '0;
            ptr_q         <= '0;
            req_vld_q     <= 1'b0;
            req_last_q    <= 1'b0;
            req_cut_id_q  <= '0;
            req_br_loop_q <= '0;
            for (int i = 0; i < BSK_CUT_NB; i++) credit_q[i] <= 4'(SLOT_NB);
        end else begin
            state_q       <= state_d;
            br_loop_q     <= br_loop_d;
            cut_nb_q      <= cut_nb_d;
            issued_q      <= issued_d;
            ptr_q         <= ptr_d;
            req_vld_q     <= req_vld_d;
            req_last_q    <= req_last_d;
            req_cut_id_q  <= req_cut_id_d;
            req_br_loop_q <= req_br_loop_d;
            credit_q      <= credit_d;
        end
    end

    for (genvar g = 0; g < BSK_CUT_NB; g++) begin : g_credit
        assign credit[g*4 +: 4] = credit_q[g];
    end

    assign req_vld     = req_vld_q;
    assign req_last    = req_last_q;
    assign req_cut_id  = req_cut_id_q;
    assign req_br_loop = req_br_loop_q;

`ifdef BSK_MGR_CUT_SCHED_PERF_EN
    logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
    logic [31:0] perf_cmd_cnt_q, perf_cmd_cnt_d;

    always_comb begin
        perf_stall_cnt_d = perf_stall_cnt_q;
        perf_cmd_cnt_d   = perf_cmd_cnt_q;
        if (state_q == ISSUE && !found && perf_stall_cnt_q != '1)
            perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
        if (state_q == WAIT && req_rdy && req_last_q && perf_cmd_cnt_q != '1)
            perf_cmd_cnt_d = perf_cmd_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (s_rst) begin
            perf_stall_cnt_q <= '0;
            perf_cmd_cnt_q   <= '0;
        end else begin
            perf_stall_cnt_q <= perf_stall_cnt_d;
            perf_cmd_cnt_q   <= perf_cmd_cnt_d;
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_q;
    assign perf_cmd_cnt   = perf_cmd_cnt_q;
`endif
endmodule

// File: tb/tb_bsk_mgr_cut_scheduler.sv
// tb_bsk_mgr_cut_scheduler: directed bench for bsk_mgr_cut_scheduler with BSK_CUT_NB=4, SLOT_NB=2.
module tb_bsk_mgr_cut_scheduler;
    logic        clk = 1'b0;
    logic        s_rst;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic [9:0]  cmd_br_loop;
    logic [2:0]  cmd_cut_nb;
    logic        req_vld;
    logic        req_rdy;
    logic [1:0]  req_cut_id;
    logic [9:0]  req_br_loop;
    logic        req_last;
    logic [3:0]  slot_release;
    logic [15:0] credit;
    logic        busy;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    bsk_mgr_cut_scheduler #(.BSK_CUT_NB(4), .SLOT_NB(2), .BR_LOOP_W(10)) dut (
        .clk(clk), .s_rst(s_rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .cmd_br_loop(cmd_br_loop), .cmd_cut_nb(cmd_cut_nb), .req_vld(req_vld),
        .req_rdy(req_rdy), .req_cut_id(req_cut_id), .req_br_loop(req_br_loop),
        .req_last(req_last), .slot_release(slot_release), .credit(credit), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [9:0] br, input logic [2:0] nb);
        int t = 0;
        while (!cmd_rdy && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("cmd_rdy_wait", cmd_rdy, 1);
        cmd_vld     = 1'b1;
        cmd_br_loop = br;
        cmd_cut_nb  = nb;
        @(negedge clk);
        cmd_vld = 1'b0;
    endtask

    task automatic get_req(input string tag, input logic [1:0] id, input logic [9:0] br, input logic last);
        int t = 0;
        while (!req_vld && t < 40) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_vld"}, req_vld, 1);
        check({tag, "_id"}, req_cut_id, id);
        check({tag, "_br"}, req_br_loop, br);
        check({tag, "_last"}, req_last, last);
        if (req_rdy) @(negedge clk);
    endtask

    task automatic pulse(input logic [3:0] rel);
        slot_release = rel;
        @(negedge clk);
        slot_release = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        s_rst = 1'b1; cmd_vld = 1'b0; cmd_br_loop = '0; cmd_cut_nb = '0;
        req_rdy = 1'b1; slot_release = '0;
        repeat (2) @(negedge clk);
        check("rst_cmd_rdy", cmd_rdy, 0);
        check("rst_req_vld", req_vld, 0);
        check("rst_busy", busy, 0);
        check("rst_credit", credit, 16'h2222);
        check("rst_cut_id", req_cut_id, 0);
        check("rst_last", req_last, 0);
        s_rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_rdy", cmd_rdy, 1);

        // full command, latency and ordering
        send_cmd(10'd5, 3'd4);
        check("lat1", req_vld, 0);
        @(negedge clk);
        check("lat2", req_vld, 1);
        get_req("t1a", 2'd0, 10'd5, 1'b0);
        get_req("t1b", 2'd1, 10'd5, 1'b0);
        get_req("t1c", 2'd2, 10'd5, 1'b0);
        get_req("t1d", 2'd3, 10'd5, 1'b1);
        check("t1_credit", credit, 16'h1111);
        check("t1_busy", busy, 0);

        // credit exhaustion and release-driven issue
        send_cmd(10'd6, 3'd4);
        get_req("t2a", 2'd0, 10'd6, 1'b0);
        get_req("t2b", 2'd1, 10'd6, 1'b0);
        get_req("t2c", 2'd2, 10'd6, 1'b0);
        get_req("t2d", 2'd3, 10'd6, 1'b1);
        check("t2_credit0", credit, 16'h0000);
        send_cmd(10'd7, 3'd4);
        repeat (4) @(negedge clk);
        check("t2_stall_vld", req_vld, 0);
        check("t2_stall_busy", busy, 1);
        pulse(4'b0100);
        get_req("t2e", 2'd2, 10'd7, 1'b0);
        repeat (4) @(negedge clk);
        check("t2_stall2_vld", req_vld, 0);
        check("t2_stall2_credit", credit, 16'h0000);
        pulse(4'b1011);
        get_req("t2f", 2'd3, 10'd7, 1'b0);
        get_req("t2g", 2'd0, 10'd7, 1'b0);
        get_req("t2h", 2'd1, 10'd7, 1'b1);
        check("t2_credit_end", credit, 16'h0000);
        pulse(4'b1111);
        pulse(4'b1111);
        check("refill", credit, 16'h2222);
        pulse(4'b1111);
        check("saturate", credit, 16'h2222);

        // partial cut count, then cut_nb=0 clamped to 4
        send_cmd(10'd8, 3'd2);
        get_req("t3a", 2'd0, 10'd8, 1'b0);
        get_req("t3b", 2'd1, 10'd8, 1'b1);
        check("t3_credit", credit, 16'h2211);
        check("t3_busy", busy, 0);
        send_cmd(10'd9, 3'd0);
        get_req("t3c", 2'd0, 10'd9, 1'b0);
        get_req("t3d", 2'd1, 10'd9, 1'b0);
        get_req("t3e", 2'd2, 10'd9, 1'b0);
        get_req("t3f", 2'd3, 10'd9, 1'b1);
        check("t3_credit_clamp", credit, 16'h1100);
        pulse(4'b0011);
        check("t3_refill", credit, 16'h1111);

        // backpressure holds the request stable
        req_rdy = 1'b0;
        send_cmd(10'd10, 3'd1);
        get_req("t4", 2'd0, 10'd10, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_vld", req_vld, 1);
            check("t4_hold_id", req_cut_id, 0);
            check("t4_hold_br", req_br_loop, 10'd10);
            check("t4_hold_credit", credit, 16'h1111);
        end
        req_rdy = 1'b1;
        @(negedge clk);
        check("t4_vld_drop", req_vld, 0);
        check("t4_credit", credit, 16'h1110);
        check("t4_busy", busy, 0);

        // accept and release on the same cut in the same cycle
        req_rdy = 1'b0;
        send_cmd(10'd3, 3'd2);
        get_req("t5a", 2'd1, 10'd3, 1'b0);
        req_rdy = 1'b1;
        slot_release = 4'b0010;
        @(negedge clk);
        slot_release = '0;
        check("t5_acc_rel_credit", credit, 16'h1110);
        check("t5_vld", req_vld, 0);
        pulse(4'b0001);
        get_req("t5b", 2'd0, 10'd3, 1'b1);
        check("t5_credit", credit, 16'h1110);

        // reset mid-command
        pulse(4'b0001);
        send_cmd(10'd7, 3'd4);
        get_req("t6a", 2'd1, 10'd7, 1'b0);
        get_req("t6b", 2'd2, 10'd7, 1'b0);
        s_rst = 1'b1;
        @(negedge clk);
        check("t6_credit", credit, 16'h2222);
        check("t6_busy", busy, 0);
        check("t6_vld", req_vld, 0);
        check("t6_cmd_rdy", cmd_rdy, 0);
        s_rst = 1'b0;
        @(negedge clk);
        send_cmd(10'd1, 3'd4);
        get_req("t6c", 2'd0, 10'd1, 1'b0);
        get_req("t6d", 2'd1, 10'd1, 1'b0);
        get_req("t6e", 2'd2, 10'd1, 1'b0);
        get_req("t6f", 2'd3, 10'd1, 1'b1);
        check("t6_credit_end", credit, 16'h1111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
